alu_cmd_sequencer: RTL and testbench

- Sequential command front-end for the team's combinational ALU (8 functions, 4 flags). It sits between a command source and one ALU instance.
- Accepts operation commands over a valid/ready handshake and drives the ALU operand/select/shamt inputs from registers.
- Captures the ALU result and flags, and returns them over a valid/ready response channel.
- Supports iterated execution, where the result is fed back as operand a, and a persistent accumulator used as operand a.

---
 rtl/alu_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for a combinational ALU: accepts op commands, runs them N times, returns result/flags.
// Latency N+1 cycles from accept to rsp_valid; rsp_ready low holds the block in RESP with outputs frozen.
module alu_cmd_sequencer #(
    parameter int BUS_SIZE = 8,
    parameter int SHAMT_W  = 3,
    parameter int ITER_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [BUS_SIZE-1:0] cmd_a,
    input  logic [BUS_SIZE-1:0] cmd_b,
    input  logic [SHAMT_W-1:0]  cmd_shamt,
    input  logic                cmd_use_acc,
    input  logic [ITER_W-1:0]   cmd_iter,
    output logic [BUS_SIZE-1:0] alu_a,
    output logic [BUS_SIZE-1:0] alu_b,
    output logic [2:0]          alu_select,
    output logic [SHAMT_W-1:0]  alu_shamt,
    input  logic [BUS_SIZE-1:0] alu_s,
    input  logic [3:0]          alu_flags,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [BUS_SIZE-1:0] rsp_result,
    output logic [3:0]          rsp_flags,
    output logic [3:0]          rsp_sticky,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [BUS_SIZE-1:0] r_a;
    logic [BUS_SIZE-1:0] r_b;
    logic [2:0]          r_op;
    logic [SHAMT_W-1:0]  r_shamt;
    logic [BUS_SIZE-1:0] r_acc;
    logic [ITER_W-1:0]   r_rem;
    logic [BUS_SIZE-1:0] r_result;
    logic [3:0]          r_flags;
    logic [3:0]          r_sticky;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic                r_busy;

    logic [ITER_W-1:0]   w_iter_eff;

    // A zero iteration count still runs the op once.
    assign w_iter_eff = (cmd_iter == '0) ? ITER_W'(1) : cmd_iter;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_shamt     <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_sticky    <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_b         <= cmd_b;
                        r_shamt     <= cmd_shamt;
                        r_a         <= cmd_use_acc ? r_acc : cmd_a;
                        r_rem       <= w_iter_eff;
                        r_sticky    <= '0;
                        r_state     <= S_EXEC;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_s;
                    r_flags  <= alu_flags;
                    r_sticky <= r_sticky | alu_flags;
                    r_acc    <= alu_s;
                    r_rem    <= r_rem - ITER_W'(1);
                    if (r_rem == ITER_W'(1)) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_a <= alu_s;
                    end
                end
                S_RESP: begin
                    // Bubble: IDLE is entered with cmd_ready rising only after the handshake edge.
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign busy       = r_busy;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_select = r_op;
    assign alu_shamt  = r_shamt;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_sticky = r_sticky;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU on the alu_* ports, expected responses queued at accept.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_shamt;
    logic       cmd_use_acc;
    logic [3:0] cmd_iter;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_select;
    logic [2:0] alu_shamt;
    logic [7:0] alu_s;
    logic [3:0] alu_flags;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [3:0] rsp_sticky;
    logic       busy;

    alu_cmd_sequencer #(.BUS_SIZE(8), .SHAMT_W(3), .ITER_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .cmd_use_acc(cmd_use_acc), .cmd_iter(cmd_iter),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_shamt(alu_shamt),
        .alu_s(alu_s), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_sticky(rsp_sticky), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU: returns {overflow, zero, negative, carry_out, s}; carry on sub means no borrow.
    function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [2:0] sh);
        logic [8:0] t;
        logic [7:0] s;
        logic       c;
        logic       v;
        t = '0; s = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                t = {1'b0, a} + {1'b0, b}; s = t[7:0]; c = t[8];
                v = (a[7] == b[7]) && (s[7] != a[7]);
            end
            3'd1: begin
                t = {1'b0, a} + {1'b0, ~b} + 9'd1; s = t[7:0]; c = t[8];
                v = (a[7] != b[7]) && (s[7] != a[7]);
            end
            3'd2: s = a << sh;
            3'd3: s = a >> sh;
            3'd4: s = a | b;
            3'd5: s = a & b;
            3'd6: s = a ^ b;
            default: s = ~a;
        endcase
        return {v, (s == 8'h00), s[7], c, s};
    endfunction

    always_comb {alu_flags, alu_s} = alu_model(alu_select, alu_a, alu_b, alu_shamt);

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic [3:0] sticky;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc = 8'h00;
    int         acc_cyc;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] last_res;
    logic [3:0] last_flg;
    logic [3:0] last_sticky;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first EXEC cycle.
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] sh, input logic use_acc, input logic [3:0] iter);
        exp_t       e;
        logic [7:0] ma;
        logic [11:0] r;
        int         n;
        int         bound;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh;
        cmd_use_acc = use_acc; cmd_iter = iter; cmd_valid = 1'b1;
        bound = 0;
        while (!cmd_ready && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        ma = use_acc ? m_acc : a;
        n = (iter == 4'd0) ? 1 : int'(iter);
        e.sticky = 4'h0; e.res = 8'h00; e.flg = 4'h0;
        for (int i = 0; i < n; i++) begin
            r = alu_model(op, ma, b, sh);
            e.res = r[7:0]; e.flg = r[11:8];
            e.sticky = e.sticky | r[11:8];
            ma = r[7:0];
        end
        m_acc = e.res;
        e.lat = n + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 3'($urandom);
        cmd_shamt = 3'($urandom); cmd_use_acc = 1'($urandom); cmd_iter = 4'($urandom);
    endtask

    // Waits for rsp_valid, optionally stalls 'hold' cycles, compares, then completes the handshake.
    task automatic get_rsp(input int hold);
        exp_t e;
        int   bound;
        if (hold > 0) rsp_ready = 1'b0;
        bound = 0;
        while (!rsp_valid && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
            rsp_ready = 1'b1;
            return;
        end
        if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
        check("busy_in_resp", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_result", 32'(rsp_result), 32'(e.res));
            check("hold_sticky", 32'(rsp_sticky), 32'(e.sticky));
        end
        check("rsp_result", 32'(rsp_result), 32'(e.res));
        check("rsp_flags", 32'(rsp_flags), 32'(e.flg));
        check("rsp_sticky", 32'(rsp_sticky), 32'(e.sticky));
        last_res = rsp_result; last_flg = rsp_flags; last_sticky = rsp_sticky;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int no_rsp;
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'h11; cmd_b = 8'h22;
        cmd_shamt = 3'd0; cmd_use_acc = 1'b0; cmd_iter = 4'd1; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_sel", 32'(alu_select), 32'd0);
        check("rst_alu_shamt", 32'(alu_shamt), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_rsp_sticky", 32'(rsp_sticky), 32'd0);

        // Add, single execution
        send_cmd(3'd0, 8'h05, 8'h03, 3'd0, 1'b0, 4'd1);
        check("t1_busy_exec", 32'(busy), 32'd1);
        check("t1_valid_exec", 32'(rsp_valid), 32'd0);
        get_rsp(0);
        check("t1_res", 32'(last_res), 32'h08);
        check("t1_flags", 32'(last_flg), 32'h0);

        // Sub equal, then sub negative
        send_cmd(3'd1, 8'h05, 8'h05, 3'd0, 1'b0, 4'd1);
        get_rsp(0);
        check("t2_res0", 32'(last_res), 32'h00);
        check("t2_flags0", 32'(last_flg), 32'b0101);
        send_cmd(3'd1, 8'h03, 8'h05, 3'd0, 1'b0, 4'd1);
        get_rsp(0);
        check("t2_res1", 32'(last_res), 32'hFE);
        check("t2_flags1", 32'(last_flg), 32'b0010);

        // Iterated shift: operand a walks 01,02,04,08
        send_cmd(3'd2, 8'h01, 8'h00, 3'd1, 1'b0, 4'd4);
        for (int i = 0; i < 4; i++) begin
            check("t3_alu_a", 32'(alu_a), 32'(1 << i));
            if (i < 3) @(negedge clk);
        end
        get_rsp(0);
        check("t3_res", 32'(last_res), 32'h10);

        // Accumulator operand with 3 cycles of response backpressure
        send_cmd(3'd0, 8'hAA, 8'h22, 3'd0, 1'b1, 4'd1);
        get_rsp(3);
        check("t5_res", 32'(last_res), 32'h32);

        // Sticky flags over three subtractions
        send_cmd(3'd1, 8'h02, 8'h01, 3'd0, 1'b0, 4'd3);
        get_rsp(0);
        check("t4_res", 32'(last_res), 32'hFF);
        check("t4_flags", 32'(last_flg), 32'b0010);
        check("t4_sticky", 32'(last_sticky), 32'b0111);

        // Iteration count boundaries: 0 runs once, all-ones runs 15 times
        send_cmd(3'd0, 8'h10, 8'h01, 3'd0, 1'b0, 4'd0);
        get_rsp(0);
        check("iter0_res", 32'(last_res), 32'h11);
        send_cmd(3'd0, 8'h00, 8'h01, 3'd0, 1'b0, 4'hF);
        get_rsp(0);
        check("iter15_res", 32'(last_res), 32'h0F);

        // Mixed random commands
        for (int i = 0; i < 10; i++) begin
            send_cmd(3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
                     1'($urandom), 4'($urandom_range(0, 3)));
            get_rsp(int'($urandom_range(0, 2)));
        end

        // Reset during the third EXEC cycle drops the command and clears the accumulator
        send_cmd(3'd0, 8'h01, 8'h01, 3'd0, 1'b0, 4'd8);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        sb.delete();
        m_acc = 8'h00;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_alu_a", 32'(alu_a), 32'd0);
        check("t6_rsp_result", 32'(rsp_result), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        no_rsp = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) no_rsp = 0;
        end
        check("t6_no_rsp", 32'(no_rsp), 32'd1);
        send_cmd(3'd0, 8'h77, 8'h00, 3'd0, 1'b1, 4'd1);
        get_rsp(0);
        check("t6_acc_cleared", 32'(last_res), 32'h00);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
